// File: rtl/conv_psum_acc.sv
// rtl/conv_psum_acc.sv - channel-group partial-sum accumulator with bias, rounding requantize and int8 saturation
// Optional build macro CONV_PSUM_RELU_EN clamps negative results to zero before saturation.
module conv_psum_acc #(
  parameter int N_CH  = 4,
  parameter int IN_W  = 20,
  parameter int ACC_W = 28,
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    vld_i,
  input  logic signed [IN_W-1:0]  acc_i,
  input  logic                    clear_i,
  input  logic signed [15:0]      bias_i,
  input  logic [4:0]              shift_i,
  output logic signed [OUT_W-1:0] dout,
  output logic                    vld_o,
  output logic                    ovf_o
);

  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int SW = ACC_W + 1;
  // Wide enough to hold the rounding constant for shift 31 without wrapping.
  localparam int RW = (ACC_W + 2 > 33) ? ACC_W + 2 : 33;
  localparam logic [CW-1:0]           LAST  = CW'(N_CH - 1);
  localparam logic signed [ACC_W-1:0] AMAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] AMIN  = ~AMAX;
  localparam logic signed [RW-1:0]    OMAX  = RW'(2**(OUT_W-1) - 1);
  localparam logic signed [RW-1:0]    OMIN  = ~OMAX;
  localparam logic [RW-1:0]           ONE   = RW'(1);

  logic [CW-1:0]           cnt, eff, cnt_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [ACC_W:0]   add_full;
  logic                    first, last, clip;

  logic                    s1_vld;
  logic signed [ACC_W-1:0] s1_sum;
  logic signed [15:0]      s1_bias;
  logic [4:0]              s1_shift;

  logic                    s2_vld;
  logic signed [SW-1:0]    s2;
  logic [4:0]              s2_shift;

  logic signed [RW-1:0]    rnd, rsum, rq;
  logic signed [OUT_W-1:0] sat;

  // A clear alongside a beat restarts the group with that beat.
  always_comb begin
    first    = clear_i || (cnt == '0);
    eff      = first ? '0 : cnt;
    last     = (eff == LAST);
    cnt_nxt  = last ? '0 : eff + CW'(1);
    add_full = (ACC_W+1)'(acc) + (ACC_W+1)'(acc_i);
    clip     = 1'b0;
    acc_nxt  = ACC_W'(acc_i);
    if (!first) begin
      if (add_full[ACC_W] != add_full[ACC_W-1]) begin
        clip    = vld_i;
        acc_nxt = add_full[ACC_W] ? AMIN : AMAX;
      end else begin
        acc_nxt = add_full[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt      <= '0;
      acc      <= '0;
      ovf_o    <= 1'b0;
      s1_vld   <= 1'b0;
      s1_sum   <= '0;
      s1_bias  <= '0;
      s1_shift <= '0;
    end else begin
      if (vld_i) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
      end else if (clear_i) begin
        acc <= '0;
        cnt <= '0;
      end
      if (clear_i)   ovf_o <= clip;
      else if (clip) ovf_o <= 1'b1;
      s1_vld <= vld_i && last;
      if (vld_i && last) begin
        s1_sum   <= acc_nxt;
        s1_bias  <= bias_i;
        s1_shift <= shift_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_vld   <= 1'b0;
      s2       <= '0;
      s2_shift <= '0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2       <= SW'(s1_sum) + SW'(s1_bias);
        s2_shift <= s1_shift;
      end
    end
  end

  always_comb begin
    rnd  = (s2_shift == '0) ? '0 : ONE << (s2_shift - 5'd1);
    rsum = RW'(s2) + rnd;
    rq   = rsum >>> s2_shift;
`ifdef CONV_PSUM_RELU_EN
    if (rq < 0) rq = '0;
`endif
    if (rq > OMAX)      sat = OMAX[OUT_W-1:0];
    else if (rq < OMIN) sat = OMIN[OUT_W-1:0];
    else                sat = rq[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_o <= 1'b0;
      dout  <= '0;
    end else begin
      vld_o <= s2_vld;
      if (s2_vld) dout <= sat;
    end
  end

endmodule

// File: tb/tb_conv_psum_acc.sv
// tb/tb_conv_psum_acc.sv - directed checks of conv_psum_acc (N_CH=4, N_CH=1 and ACC_W=21 instances)
module tb_conv_psum_acc;

  logic              clk = 1'b0;
  logic              rstn;
  logic              vld_i;
  logic signed [19:0] acc_i;
  logic              clear_i;
  logic signed [15:0] bias_i;
  logic [4:0]        shift_i;

  logic signed [7:0] dout, dout1, dout21;
  logic              vld_o, vld1, vld21;
  logic              ovf_o, ovf1, ovf21;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int last_dout = 0;

  always #5 clk = ~clk;

  conv_psum_acc #(.N_CH(4), .IN_W(20), .ACC_W(28), .OUT_W(8)) dut (
    .clk(clk), .rstn(rstn), .vld_i(vld_i), .acc_i(acc_i), .clear_i(clear_i),
    .bias_i(bias_i), .shift_i(shift_i), .dout(dout), .vld_o(vld_o), .ovf_o(ovf_o));

  conv_psum_acc #(.N_CH(1), .IN_W(20), .ACC_W(28), .OUT_W(8)) dut1 (
    .clk(clk), .rstn(rstn), .vld_i(vld_i), .acc_i(acc_i), .clear_i(clear_i),
    .bias_i(bias_i), .shift_i(shift_i), .dout(dout1), .vld_o(vld1), .ovf_o(ovf1));

  conv_psum_acc #(.N_CH(4), .IN_W(20), .ACC_W(21), .OUT_W(8)) dut21 (
    .clk(clk), .rstn(rstn), .vld_i(vld_i), .acc_i(acc_i), .clear_i(clear_i),
    .bias_i(bias_i), .shift_i(shift_i), .dout(dout21), .vld_o(vld21), .ovf_o(ovf21));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (vld_o) begin
      pulses++;
      last_dout = int'(dout);
    end
  endtask

  task automatic send(input int a, input logic clr);
    vld_i   = 1'b1;
    acc_i   = 20'(a);
    clear_i = clr;
    tick();
    vld_i   = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic flush();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rstn = 1'b0; vld_i = 1'b0; acc_i = '0; clear_i = 1'b0; bias_i = '0; shift_i = '0;
    idle(3);
    check("reset_dout", int'(dout), 0);
    check("reset_vld", int'(vld_o), 0);
    check("reset_ovf", int'(ovf_o), 0);
    rstn = 1'b1;
    idle(1);

    // Basic group: (1000+8)>>4 = 63, exactly two cycles after the last beat.
    shift_i = 5'd4; bias_i = 16'sd0;
    send(100, 1'b0); send(200, 1'b0); send(300, 1'b0); send(400, 1'b0);
    check("basic_vld_lat0", int'(vld_o), 0);
    tick();
    check("basic_vld_lat1", int'(vld_o), 0);
    tick();
    check("basic_vld_lat2", int'(vld_o), 1);
    check("basic_dout", int'(dout), 63);
    tick();
    check("basic_vld_pulse", int'(vld_o), 0);
    check("basic_dout_hold", int'(dout), 63);

    // Rounding on the N_CH=1 instance, back-to-back beats.
    flush();
    send(24, 1'b0); send(23, 1'b0); send(-24, 1'b0);
    check("rnd_vld_a", int'(vld1), 1);
    check("rnd_24", int'(dout1), 2);
    tick();
    check("rnd_vld_b", int'(vld1), 1);
    check("rnd_23", int'(dout1), 1);
    tick();
    check("rnd_vld_c", int'(vld1), 1);
    check("rnd_m24", int'(dout1), -1);
    tick();
    check("rnd_vld_end", int'(vld1), 0);

    // Negative saturation / relu clamp.
    flush();
    for (int i = 0; i < 4; i++) send(-1000, 1'b0);
    idle(2);
`ifdef CONV_PSUM_RELU_EN
    check("neg_sat", int'(dout), 0);
`else
    check("neg_sat", int'(dout), -128);
`endif

    // Positive saturation; accumulator overflow only in the narrow instance.
    flush();
    shift_i = 5'd0;
    for (int i = 0; i < 4; i++) send(524287, 1'b0);
    idle(2);
    check("pos_sat", int'(dout), 127);
    check("pos_ovf_wide", int'(ovf_o), 0);
    check("pos_sat_narrow", int'(dout21), 127);
    check("pos_ovf_narrow", int'(ovf21), 1);
    idle(3);
    check("ovf_sticky", int'(ovf21), 1);
    flush();
    check("ovf_cleared", int'(ovf21), 0);

    // Partial group flushed, then a gapped group with bias.
    bias_i = 16'sd5; shift_i = 5'd0;
    pulses = 0;
    send(999, 1'b0); send(999, 1'b0);
    flush();
    send(10, 1'b0); idle(1); send(10, 1'b0); idle(2); send(10, 1'b0); send(10, 1'b0);
    idle(5);
    check("flush_pulses", pulses, 1);
    check("flush_dout", last_dout, 45);

    // Clear coincident with the first beat discards the stale partial.
    bias_i = 16'sd0;
    send(500, 1'b0);
    send(10, 1'b1); send(10, 1'b0); send(10, 1'b0); send(10, 1'b0);
    idle(2);
    check("clrbeat_vld", int'(vld_o), 1);
    check("clrbeat_dout", int'(dout), 40);

    // Asynchronous reset mid-clock wipes outputs, flags and the partial group.
    idle(2);
    for (int i = 0; i < 3; i++) send(524287, 1'b0);
    check("pre_rst_ovf21", int'(ovf21), 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_dout", int'(dout), 0);
    check("arst_vld", int'(vld_o), 0);
    check("arst_ovf", int'(ovf21), 0);
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) send(1, 1'b0);
    idle(2);
    check("post_rst_vld", int'(vld_o), 1);
    check("post_rst_dout", int'(dout), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_psum_acc.md
Name: conv_psum_acc

Overview:
- Post-MAC stage that sits directly downstream of the 3x3 multiply-accumulate unit and consumes its 20-bit signed dot-product beats.
- Accumulates N_CH consecutive beats, one per input-channel group, into one output-pixel partial sum.
- Adds a per-output-channel bias, requantizes by arithmetic right shift with rounding, and saturates to a signed 8-bit activation for the next layer.

Parameters:
- N_CH, 4, number of vld_i beats summed per output pixel (>=1).
- IN_W, 20, width of the signed input partial sum.
- ACC_W, 28, width of the signed internal accumulator (>= IN_W).
- OUT_W, 8, width of the signed output activation.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- vld_i  in  1  acc_i is valid this cycle.
- acc_i  in  IN_W  signed partial sum from the MAC.
- clear_i  in  1  synchronous flush of the group in progress.
- bias_i  in  16  signed bias, sampled on the group's last beat.
- shift_i  in  5  requantization right-shift amount 0..31, sampled on the group's last beat.
- dout  out  OUT_W  signed saturated activation.
- vld_o  out  1  dout valid, single-cycle pulse.
- ovf_o  out  1  sticky flag: accumulator saturated.

Behaviour:
- Reset (rstn=0, asynchronous): beat counter=0, accumulator=0, all pipeline registers=0, dout=0, vld_o=0, ovf_o=0. No partial group survives reset.
- Stage 1 (accumulate):
  - On vld_i with counter=0: acc <= sext(acc_i).
  - Otherwise on vld_i: acc <= sat_ACC_W(acc + sext(acc_i)).
  - Counter increments per beat and wraps to 0 after beat N_CH-1.
  - If the saturating add clips, set ovf_o.
- Last beat (counter==N_CH-1 with vld_i): the completed sum, bias_i and shift_i are registered into stage 2, and stage-2 valid is set.
- Stage 2 (bias): s2 = final sum + sext(bias_i), computed at ACC_W+1 bits with no wrap.
- Stage 3 (requantize):
  - shift_i==0: r = s2.
  - Otherwise: r = (s2 + (1<<(shift_i-1))) >>> shift_i (round half up, arithmetic shift).
  - Then saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and register it into dout.
- Timing:
  - vld_o pulses exactly 2 cycles after the clock edge that accepts the group's last beat.
  - dout holds its value until the next vld_o.
- Throughput: one beat per cycle, no backpressure. With N_CH=1, back-to-back beats give back-to-back vld_o.
- vld_i low: all state holds and gaps between beats are allowed. acc_i is ignored when vld_i=0.
- clear_i:
  - Zeroes the counter and accumulator.
  - Results already in stages 2/3 still complete.
  - clear_i together with vld_i: the beat is taken as the first beat of a new group (acc=acc_i, counter=1).
  - Clears ovf_o unless an overflow occurs in the same cycle.
- N_CH=1: every vld_i beat is a last beat.

Optional Feature:
- CONV_PSUM_RELU_EN.
- Defined: after rounding, negative r clamps to 0 before saturation, so dout is in [0, 2^(OUT_W-1)-1].
- Undefined: signed saturation only. Latency is identical in both builds.

Test Plan:
- N_CH=4, acc_i=100,200,300,400 on consecutive cycles, bias=0, shift=4 -> dout=63 ((1000+8)>>4), vld_o high one cycle, 2 cycles after the 4th beat.
- Rounding, N_CH=1, shift=4, bias=0: acc_i=24 -> dout=2. acc_i=23 -> dout=1. acc_i=-24 -> dout=-1. Beats sent back-to-back give three consecutive vld_o pulses.
- Negative saturation: N_CH=4, acc_i=-1000 x4, shift=4 -> dout=-128 without CONV_PSUM_RELU_EN, dout=0 with it. Positive case: acc_i=524287 x4, shift=0 -> dout=127, ovf_o=0. Same stimulus with ACC_W=21 -> ovf_o=1 and it stays set until clear_i.
- Flush: 2 beats of 999, then clear_i alone, then 4 beats of acc_i=10 with idle gaps, bias=5, shift=0 -> exactly one vld_o, dout=45.
- clear_i asserted with the first beat of 10 (group 10,10,10,10, shift=0, bias=0) after a stale partial beat of 500 -> dout=40.
- rstn pulsed low asynchronously mid-clock after 3 beats -> dout=0, vld_o=0, ovf_o=0 immediately. The following 4 beats of 1 with shift=0 -> dout=4.
